// File: rtl/ble_auth_rx.sv
// BLE 8N1 command receiver plus rider-authorization FSM driving pwr_up.
// Optional heartbeat timeout in PWR1 is enabled by defining AUTH_TIMEOUT_EN.
//
// rx state | meaning
// IDLE     | line idle, waiting for a falling edge on synchronized RX
// RECV     | sampling start, 8 data and stop bit at mid-bit
//
// auth state | meaning
// OFF        | not authorized, pwr_up low
// PWR1       | authorized and running
// PWR2       | stop requested, waiting for rider_off
module ble_auth_rx #(
    parameter int          BAUD_DIV   = 5208,
    parameter logic [7:0]  GO_CODE    = 8'h47,
    parameter logic [7:0]  STOP_CODE  = 8'h53,
    parameter logic [23:0] TMO_CYCLES = 24'hFFFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    // Reload one less than BAUD_DIV since the zero cycle itself is part of the period.
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    localparam logic [1:0] OFF  = 2'd0;
    localparam logic [1:0] PWR1 = 2'd1;
    localparam logic [1:0] PWR2 = 2'd2;

    logic          rx_ff1, rx_ff2;
    logic [0:0]    rx_state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;
    logic [1:0]    auth_state, auth_next;
    logic          go_rx, stop_rx, tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1 <= 1'b1;
            rx_ff2 <= 1'b1;
        end else begin
            rx_ff1 <= RX;
            rx_ff2 <= rx_ff1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= 8'h00;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (!rx_ff2) begin
                        rx_state <= RECV;
                        baud_cnt <= HALF_BIT;
                        bit_cnt  <= '0;
                    end
                end
                RECV: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end else begin
                        baud_cnt <= FULL_BIT;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd0) begin
                            if (rx_ff2) rx_state <= IDLE;
                        end else begin
                            shift <= {rx_ff2, shift[8:1]};
                            if (bit_cnt == 4'd9) begin
                                rx_state <= IDLE;
                                if (rx_ff2) begin
                                    rx_data <= shift[8:1];
                                    rx_rdy  <= 1'b1;
                                end else begin
                                    frm_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

`ifdef AUTH_TIMEOUT_EN
    logic [23:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (rx_rdy || auth_state == OFF) begin
            tmo_cnt <= '0;
        end else if (auth_state == PWR1 && tmo_cnt != TMO_CYCLES) begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end
    end

    assign tmo_hit = (auth_state == PWR1) && (tmo_cnt == TMO_CYCLES);
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    assign go_rx   = rx_rdy && (rx_data == GO_CODE);
    assign stop_rx = (rx_rdy && (rx_data == STOP_CODE)) || tmo_hit;

    always_comb begin
        auth_next = auth_state;
        case (auth_state)
            OFF:     if (go_rx) auth_next = PWR1;
            PWR1:    if (stop_rx) auth_next = rider_off ? OFF : PWR2;
            PWR2: begin
                if (go_rx)          auth_next = PWR1;
                else if (rider_off) auth_next = OFF;
            end
            default: auth_next = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auth_state <= OFF;
            pwr_up     <= 1'b0;
        end else begin
            auth_state <= auth_next;
            pwr_up     <= (auth_next != OFF);
        end
    end

endmodule

// File: tb/tb_ble_auth_rx.sv
// Directed bench for ble_auth_rx at BAUD_DIV=16; timeout steps run when AUTH_TIMEOUT_EN is defined.
module tb_ble_auth_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;

    int n_cmp = 0;
    int n_bad = 0;

    int         rdy_cnt = 0;
    int         frm_cnt = 0;
    logic [7:0] hist [0:15];
    logic       pwr_at_rdy = 1'b0;
    logic       pwr_after = 1'b0;
    logic       rdy_prev = 1'b0;

    ble_auth_rx #(
        .BAUD_DIV  (16),
        .GO_CODE   (8'h47),
        .STOP_CODE (8'h53),
        .TMO_CYCLES(24'd1000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .rider_off(rider_off),
        .pwr_up   (pwr_up),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    // Passive capture of output pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (rdy_prev) pwr_after = pwr_up;
        rdy_prev = rx_rdy;
        if (rx_rdy) begin
            hist[rdy_cnt[3:0]] = rx_data;
            pwr_at_rdy = pwr_up;
            rdy_cnt = rdy_cnt + 1;
        end
        if (frm_err) frm_cnt = frm_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk) RX = b;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        RX = 1'b1;
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_pwr_up", pwr_up, 0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_rdy", rx_rdy, 0);
        check("reset_frm_err", frm_err, 0);
        rst_n = 1'b1;
        idle(5);

        send_byte(8'h47, 1'b1);
        idle(4);
        check("go_rdy_cnt", rdy_cnt, 1);
        check("go_data", hist[0], 8'h47);
        check("go_pwr_at_rdy", pwr_at_rdy, 0);
        check("go_pwr_after", pwr_after, 1);

        send_byte(8'h53, 1'b1);
        idle(4);
        check("stop_data", hist[1], 8'h53);
        check("stop_pwr2_held", pwr_up, 1);
        rider_off = 1'b1;
        check("pwr2_before_off", pwr_up, 1);
        @(negedge clk);
        check("pwr2_rider_off", pwr_up, 0);
        rider_off = 1'b0;
        idle(4);

        send_byte(8'h47, 1'b1);
        idle(4);
        check("go2_pwr", pwr_up, 1);
        rider_off = 1'b1;
        idle(10);
        check("pwr1_ignores_rider_off", pwr_up, 1);
        send_byte(8'h53, 1'b1);
        idle(4);
        check("stop_off_at_rdy", pwr_at_rdy, 1);
        check("stop_off_after", pwr_after, 0);
        send_byte(8'h53, 1'b1);
        idle(4);
        check("stop_in_off", pwr_up, 0);
        check("stop_in_off_cnt", rdy_cnt, 5);
        rider_off = 1'b0;

        send_byte(8'h47, 1'b0);
        idle(40);
        check("frm_err_cnt", frm_cnt, 1);
        check("frm_err_no_rdy", rdy_cnt, 5);
        check("frm_err_data_kept", rx_data, 8'h53);
        check("frm_err_pwr", pwr_up, 0);

        // Low pulse shorter than half a bit is rejected at the start-bit sample.
        @(negedge clk) RX = 1'b0;
        repeat (6) @(negedge clk);
        idle(40);
        check("glitch_rdy", rdy_cnt, 5);
        check("glitch_frm", frm_cnt, 1);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h47, 1'b1);
        idle(4);
        check("b2b_cnt", rdy_cnt, 7);
        check("b2b_first", hist[5], 8'hA5);
        check("b2b_second", hist[6], 8'h47);
        check("b2b_pwr", pwr_up, 1);

        send_byte(8'hA5, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("partial_pre_reset_cnt", rdy_cnt, 8);
        @(negedge clk) rst_n = 1'b0;
        RX = 1'b1;
        #1;
        check("rst_mid_pwr", pwr_up, 0);
        check("rst_mid_data", rx_data, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("post_rst_no_rdy", rdy_cnt, 8);
        send_byte(8'h47, 1'b1);
        idle(4);
        check("post_rst_cnt", rdy_cnt, 9);
        check("post_rst_data", rx_data, 8'h47);
        check("post_rst_pwr", pwr_up, 1);

`ifdef AUTH_TIMEOUT_EN
        idle(1100);
        check("tmo_pwr2_held", pwr_up, 1);
        rider_off = 1'b1;
        @(negedge clk);
        check("tmo_pwr2_off", pwr_up, 0);
        rider_off = 1'b0;
        idle(4);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'h47, 1'b1);
            idle(340);
        end
        rider_off = 1'b1;
        idle(3);
        check("heartbeat_keeps_pwr1", pwr_up, 1);
        rider_off = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
